// File: rtl/control_unit.sv
// rtl/control_unit.sv - FSM controller producing the memory_system datapath control word
//
// Ports:
//   clk, rst                       clock (rising edge), asynchronous active-low reset
//   run                            leave INIT and start fetching
//   instruction[4:0]               IR contents from memory_system
//   C, N, P, Z                     ALU flags (only Z steers the FSM, in JZ2)
//   ir_sclr, mar_sclr              synchronous clear of IR / MAR
//   enaf                           flag update enable
//   selop[2:0], shamt[1:0]         ALU operation and shift amount
//   bank_wr_en                     write busC into bank[busC_addr]
//   busB_addr[2:0], busC_addr[2:0] bank read / write addresses
//   ir_en, mar_en                  IR <= busC, MAR <= bus_alu
//   wr_rdn                         1 = mem[MAR] <= MDR, 0 = read
//   mdr_alu_n                      busC/MDR source: 1 = MDR, 0 = ALU
//   mdr_en                         MDR load
//   halted                         high in HALT
//   illegal                        one-cycle pulse on an undefined opcode
module control_unit #(
  parameter logic [2:0] REG_PC    = 3'd0,
  parameter logic [2:0] REG_DPTR  = 3'd1,
  parameter logic [2:0] REG_A     = 3'd2,
  parameter logic [2:0] REG_ACC   = 3'd4,
  parameter logic [2:0] SEL_PASS  = 3'b000,
  parameter logic [2:0] SEL_INC   = 3'b001,
  parameter logic [1:0] ALU_SHAMT = 2'b01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [4:0] instruction,
  input  logic       C,
  input  logic       N,
  input  logic       P,
  input  logic       Z,
  output logic       ir_sclr,
  output logic       mar_sclr,
  output logic       enaf,
  output logic [2:0] selop,
  output logic [1:0] shamt,
  output logic       bank_wr_en,
  output logic [2:0] busB_addr,
  output logic [2:0] busC_addr,
  output logic       ir_en,
  output logic       mar_en,
  output logic       wr_rdn,
  output logic       mdr_alu_n,
  output logic       mdr_en,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [4:0] {
    S_INIT, S_F0, S_F1, S_F2, S_DEC,
    S_LI0, S_LI1, S_LI2,
    S_LD0, S_LD1, S_LD2,
    S_ST0, S_ST1, S_ST2,
    S_AL0,
    S_JZ0, S_JZ1, S_JZ2,
    S_HALT
  } state_t;

  state_t state_q, state_d;

  // C, N and P are part of the flag bundle but no state consumes them.
  logic unused_flags;
  assign unused_flags = ^{C, N, P};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    ir_sclr    = 1'b0;
    mar_sclr   = 1'b0;
    enaf       = 1'b0;
    selop      = SEL_PASS;
    shamt      = 2'b00;
    bank_wr_en = 1'b0;
    busB_addr  = 3'd0;
    busC_addr  = 3'd0;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    wr_rdn     = 1'b0;
    mdr_alu_n  = 1'b0;
    mdr_en     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;

    unique case (state_q)
      S_INIT: begin
        ir_sclr  = 1'b1;
        mar_sclr = 1'b1;
        if (run) state_d = S_F0;
      end
      // Fetch, and the operand fetch of LDI/JZ, share the MAR<=PC / PC++ words.
      S_F0, S_LI0, S_JZ0: begin
        busB_addr = REG_PC;
        mar_en    = 1'b1;
        state_d   = (state_q == S_F0)  ? S_F1  :
                    (state_q == S_LI0) ? S_LI1 : S_JZ1;
      end
      S_F1, S_LI1, S_JZ1: begin
        mdr_en     = 1'b1;
        busB_addr  = REG_PC;
        busC_addr  = REG_PC;
        selop      = SEL_INC;
        bank_wr_en = 1'b1;
        state_d    = (state_q == S_F1)  ? S_F2  :
                     (state_q == S_LI1) ? S_LI2 : S_JZ2;
      end
      S_F2: begin
        mdr_alu_n = 1'b1;
        ir_en     = 1'b1;
        state_d   = S_DEC;
      end
      S_DEC: begin
        casez (instruction)
          5'b00000: state_d = S_F0;
          5'b00001: state_d = S_LI0;
          5'b00010: state_d = S_LD0;
          5'b00011: state_d = S_ST0;
          5'b01???: state_d = S_AL0;
          5'b10000: state_d = S_JZ0;
          5'b11111: state_d = S_HALT;
          default: begin
            illegal = 1'b1;
            state_d = S_F0;
          end
        endcase
      end
      S_LI2, S_LD2: begin
        mdr_alu_n  = 1'b1;
        busC_addr  = REG_ACC;
        bank_wr_en = 1'b1;
        state_d    = S_F0;
      end
      S_LD0: begin
        busB_addr = REG_DPTR;
        mar_en    = 1'b1;
        state_d   = S_LD1;
      end
      S_LD1: begin
        mdr_en  = 1'b1;
        state_d = S_LD2;
      end
      S_ST0: begin
        busB_addr = REG_DPTR;
        mar_en    = 1'b1;
        state_d   = S_ST1;
      end
      S_ST1: begin
        busB_addr = REG_ACC;
        selop     = SEL_PASS;
        mdr_en    = 1'b1;
        state_d   = S_ST2;
      end
      S_ST2: begin
        wr_rdn  = 1'b1;
        state_d = S_F0;
      end
      S_AL0: begin
        busB_addr  = REG_A;
        selop      = instruction[2:0];
        shamt      = ALU_SHAMT;
        enaf       = 1'b1;
        busC_addr  = REG_ACC;
        bank_wr_en = 1'b1;
        state_d    = S_F0;
      end
      S_JZ2: begin
        // Z is taken live this cycle; the target was just loaded into MDR.
        if (Z) begin
          mdr_alu_n  = 1'b1;
          busC_addr  = REG_PC;
          bank_wr_en = 1'b1;
        end
        state_d = S_F0;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_INIT;
    endcase
  end

endmodule
